// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle core with req/ack instruction fetch and debug reads.
// Define CPU_MC_SHIFT_EN to build the sll/srl opcodes (9/10).
module cpu_mc #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    output logic [31:0]                  PC,
    output logic                         IMEM_REQ,
    input  logic                         IMEM_ACK,
    input  logic [31:0]                  INSTRUCTION,
    output logic                         RETIRE,
    output logic                         HALTED,
    output logic                         ILLEGAL,
    input  logic [$clog2(REG_COUNT)-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]            DBG_DATA
);
    localparam int RI = $clog2(REG_COUNT);
`ifdef CPU_MC_SHIFT_EN
    localparam int SW = $clog2(DATA_W);
`endif

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              take_q, take_d;
    logic              req_q, req_d;
    logic              retire_q, retire_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];

    logic [7:0]        op, imm;
    logic [RI-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0] a, b, alu;
    logic              legal, wr_en;
    logic [31:0]       seq_pc, br_pc;
    logic              unused_ok;

    assign op     = ir_q[31:24];
    assign imm    = ir_q[7:0];
    assign rd     = ir_q[16 +: RI];
    assign rs1    = ir_q[8 +: RI];
    assign rs2    = ir_q[0 +: RI];
    assign a      = regs_q[rs1];
    assign b      = regs_q[rs2];
    assign seq_pc = pc_q + 32'd4;
    assign br_pc  = seq_pc + (32'($signed(ir_q[23:16])) << 2);
    // Only the low RI bits of the source-1 field select a register.
    assign unused_ok = ^ir_q[15:8];

    always_comb begin
        alu   = '0;
        legal = 1'b1;
        wr_en = 1'b0;
        case (op)
            8'd0: begin alu = DATA_W'($signed(imm)); wr_en = 1'b1; end
            8'd1: begin alu = b;                     wr_en = 1'b1; end
            8'd2: begin alu = a + b;                 wr_en = 1'b1; end
            8'd3: begin alu = a + (~b + DATA_W'(1)); wr_en = 1'b1; end
            8'd4: begin alu = a & b;                 wr_en = 1'b1; end
            8'd5: begin alu = a | b;                 wr_en = 1'b1; end
`ifdef CPU_MC_SHIFT_EN
            8'd9:  begin alu = a << imm[SW-1:0]; wr_en = 1'b1; end
            8'd10: begin alu = a >> imm[SW-1:0]; wr_en = 1'b1; end
`endif
            8'd6, 8'd7, 8'd8, 8'hFF: ;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        take_d    = take_q;
        req_d     = 1'b0;
        retire_d  = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        regs_d    = regs_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                req_d = 1'b1;
                if (IMEM_ACK) begin
                    ir_d    = INSTRUCTION;
                    state_d = EXEC;
                    req_d   = 1'b0;
                end
            end
            EXEC: begin
                res_d    = alu;
                take_d   = (op == 8'd6) ||
                           (op == 8'd7 && a == b) ||
                           (op == 8'd8 && a != b);
                state_d  = WB;
                retire_d = 1'b1;
            end
            WB: begin
                if (op == 8'hFF) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    if (wr_en) regs_d[rd] = res_q;
                    pc_d      = take_q ? br_pc : seq_pc;
                    illegal_d = illegal_q | ~legal;
                    state_d   = FETCH;
                    req_d     = 1'b1;
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            res_q     <= '0;
            take_q    <= 1'b0;
            req_q     <= 1'b0;
            retire_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            res_q     <= res_d;
            take_q    <= take_d;
            req_q     <= req_d;
            retire_q  <= retire_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            regs_q    <= regs_d;
        end
    end

    assign PC       = pc_q;
    assign IMEM_REQ = req_q;
    assign RETIRE   = retire_q;
    assign HALTED   = halted_q;
    assign ILLEGAL  = illegal_q;
    assign DBG_DATA = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed programs plus random instruction streams for cpu_mc,
// checked against an instruction-level reference model.
module tb_cpu_mc;
    localparam int     DW   = 16;
    localparam int     RC   = 8;
    localparam int     RI   = $clog2(RC);
    localparam int     SW   = $clog2(DW);
    localparam longint MASK = (64'd1 << DW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   PC;
    logic          IMEM_REQ;
    logic          IMEM_ACK;
    logic [31:0]   INSTRUCTION;
    logic          RETIRE;
    logic          HALTED;
    logic          ILLEGAL;
    logic [RI-1:0] DBG_ADDR;
    logic [DW-1:0] DBG_DATA;

    always #20 CLK = ~CLK;

    cpu_mc #(.DATA_W(DW), .REG_COUNT(RC)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_REQ(IMEM_REQ),
        .IMEM_ACK(IMEM_ACK), .INSTRUCTION(INSTRUCTION), .RETIRE(RETIRE),
        .HALTED(HALTED), .ILLEGAL(ILLEGAL), .DBG_ADDR(DBG_ADDR),
        .DBG_DATA(DBG_DATA)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] imem [64];
    longint      mreg [RC];
    logic [31:0] mpc;
    logic        mhalt, mill;
    logic [31:0] v;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input int r, output logic [31:0] val);
        DBG_ADDR = RI'(r);
        #1;
        val = 32'(DBG_DATA);
    endtask

    task automatic check_regs();
        logic [31:0] x;
        for (int r = 0; r < RC; r++) begin
            rd_reg(r, x);
            chk($sformatf("reg%0d", r), x, 32'(mreg[r]));
        end
    endtask

    task automatic model_step(input logic [31:0] ins);
        logic [7:0]  op, imm;
        int          d, s1, s2;
        longint      a, b;
        logic [31:0] npc;
        op  = ins[31:24];
        imm = ins[7:0];
        d   = int'(ins[23:16]) % RC;
        s1  = int'(ins[15:8]) % RC;
        s2  = int'(ins[7:0]) % RC;
        a   = mreg[s1];
        b   = mreg[s2];
        npc = mpc + 32'd4;
        case (op)
            8'd0: mreg[d] = longint'($signed(imm)) & MASK;
            8'd1: mreg[d] = b;
            8'd2: mreg[d] = (a + b) & MASK;
            8'd3: mreg[d] = (a - b) & MASK;
            8'd4: mreg[d] = a & b;
            8'd5: mreg[d] = a | b;
            8'd6: npc = npc + 32'(4 * int'($signed(ins[23:16])));
            8'd7: if (a == b) npc = npc + 32'(4 * int'($signed(ins[23:16])));
            8'd8: if (a != b) npc = npc + 32'(4 * int'($signed(ins[23:16])));
`ifdef CPU_MC_SHIFT_EN
            8'd9:  mreg[d] = (a << (int'(imm) % (2 ** SW))) & MASK;
            8'd10: mreg[d] = a >> (int'(imm) % (2 ** SW));
`endif
            8'hFF: mhalt = 1'b1;
            default: mill = 1'b1;
        endcase
        if (!mhalt) mpc = npc;
    endtask

    // Precondition: at a negedge with the core in FETCH.
    task automatic step(input int stall);
        logic [31:0] ins, pc0;
        pc0 = mpc;
        ins = imem[mpc[7:2]];
        for (int i = 0; i < stall; i++) begin
            chk("req_stall", 32'(IMEM_REQ), 32'd1);
            chk("pc_stall", PC, pc0);
            chk("ret_stall", 32'(RETIRE), 32'd0);
            IMEM_ACK = 1'b0;
            INSTRUCTION = $urandom;
            @(negedge CLK);
        end
        chk("req_fetch", 32'(IMEM_REQ), 32'd1);
        chk("pc_fetch", PC, pc0);
        chk("ret_fetch", 32'(RETIRE), 32'd0);
        IMEM_ACK = 1'b1;
        INSTRUCTION = ins;
        @(negedge CLK);
        chk("ret_exec", 32'(RETIRE), 32'd0);
        chk("req_exec", 32'(IMEM_REQ), 32'd0);
        IMEM_ACK = 1'($urandom);
        INSTRUCTION = $urandom;
        @(negedge CLK);
        chk("retire", 32'(RETIRE), 32'd1);
        chk("pc_wb", PC, pc0);
        IMEM_ACK = 1'($urandom);
        INSTRUCTION = $urandom;
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        model_step(ins);
        chk("pc", PC, mpc);
        chk("ret_off", 32'(RETIRE), 32'd0);
        chk("halted", 32'(HALTED), 32'(mhalt));
        chk("illegal", 32'(ILLEGAL), 32'(mill));
        chk("req_next", 32'(IMEM_REQ), 32'(!mhalt));
        check_regs();
    endtask

    task automatic do_reset(input logic ack_noise);
        RESET = 1'b0;
        IMEM_ACK = ack_noise;
        INSTRUCTION = 32'h0005_007F;
        @(negedge CLK);
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        mpc = '0;
        mhalt = 1'b0;
        mill = 1'b0;
        for (int r = 0; r < RC; r++) mreg[r] = 0;
        chk("rst_pc", PC, 32'd0);
        chk("rst_req", 32'(IMEM_REQ), 32'd0);
        chk("rst_ret", 32'(RETIRE), 32'd0);
        chk("rst_halt", 32'(HALTED), 32'd0);
        chk("rst_ill", 32'(ILLEGAL), 32'd0);
        check_regs();
        RESET = 1'b1;
        @(negedge CLK);
        chk("req_rise", 32'(IMEM_REQ), 32'd1);
        chk("pc_rise", PC, 32'd0);
    endtask

    function automatic logic [31:0] rnd_ins();
        int         k;
        logic [7:0] op;
        k = $urandom_range(0, 12);
        if (k <= 10)      op = 8'(k);
        else if (k == 11) op = 8'h20;
        else              op = 8'($urandom_range(11, 254));
        return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    initial begin
        RESET = 1'b0;
        IMEM_ACK = 1'b0;
        INSTRUCTION = '0;
        DBG_ADDR = '0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h2000_0000;

        // Arithmetic, sign extension, then a stalled fetch.
        imem[0] = 32'h0000_0009;
        imem[1] = 32'h0001_0004;
        imem[2] = 32'h0302_0001;
        imem[3] = 32'h0203_0201;
        imem[4] = 32'h0004_0080;
        imem[5] = 32'h0005_0011;
        do_reset(1'b0);
        repeat (4) step(0);
        chk("pc16", PC, 32'd16);
        rd_reg(2, v); chk("r2_sub", v, 32'd5);
        rd_reg(3, v); chk("r3_add", v, 32'd9);
        step(0);
        rd_reg(4, v); chk("r4_sext", v, 32'hFF80);
        step(3);
        chk("pc_stall_end", PC, 32'd24);

        // Reset in the middle of a fetch with ACK high.
        step(0);
        do_reset(1'b1);

        // Branches.
        imem[0] = 32'h0001_0005;
        imem[1] = 32'h0601_0000;
        imem[2] = 32'hFF00_0000;
        imem[3] = 32'h0002_0005;
        imem[4] = 32'h07FE_0102;
        step(0);
        step(1);
        chk("pc_j", PC, 32'd12);
        step(0);
        step(2);
        chk("pc_beq", PC, 32'd12);
        imem[4] = 32'h08FE_0102;
        step(0);
        step(0);
        chk("pc_bne", PC, 32'd20);

        // Shift and illegal opcodes.
        do_reset(1'b0);
        imem[0] = 32'h0000_0009;
        imem[1] = 32'h0903_0002;
        imem[2] = 32'h2000_0000;
        step(0);
        step(0);
        rd_reg(3, v);
`ifdef CPU_MC_SHIFT_EN
        chk("sll_r3", v, 32'd36);
        chk("sll_ill", 32'(ILLEGAL), 32'd0);
`else
        chk("sll_r3", v, 32'd0);
        chk("sll_ill", 32'(ILLEGAL), 32'd1);
`endif
        chk("sll_pc", PC, 32'd8);
        step(0);
        chk("ill_20", 32'(ILLEGAL), 32'd1);
        chk("ill_pc", PC, 32'd12);

        // Halt, then reset out of it.
        do_reset(1'b0);
        imem[0] = 32'h0001_0001;
        imem[1] = 32'h0002_0002;
        imem[2] = 32'hFF00_0000;
        repeat (3) step(0);
        for (int i = 0; i < 4; i++) begin
            IMEM_ACK = 1'b1;
            INSTRUCTION = imem[0];
            @(negedge CLK);
            chk("halt_flag", 32'(HALTED), 32'd1);
            chk("halt_pc", PC, 32'd8);
            chk("halt_req", 32'(IMEM_REQ), 32'd0);
            chk("halt_ret", 32'(RETIRE), 32'd0);
        end
        IMEM_ACK = 1'b0;
        do_reset(1'b0);
        step(0);
        chk("refetch_pc", PC, 32'd4);

        // Random instruction streams with random fetch stalls.
        for (int run = 0; run < 3; run++) begin
            for (int i = 0; i < 64; i++) imem[i] = rnd_ins();
            do_reset(1'($urandom));
            for (int n = 0; n < 60; n++) step($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
